// File: rtl/arb_mux.sv
// arb_mux: N-channel valid/ready arbiter-multiplexer with one registered output stage.
module arb_mux #(
  parameter  int WIDTH = 32,
  parameter  int N     = 4,
  parameter  int MODE  = 0,
  localparam int SELW  = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW-1:0]      out_sel
);
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic [SELW-1:0]  r_sel;
  logic [SELW-1:0]  r_ptr;
  logic [SELW-1:0]  w_base;
  logic [SELW-1:0]  w_grant;
  logic [SELW:0]    w_sum;
  logic             w_load;
  logic             w_any;
  assign w_load = !r_valid | out_ready;
  assign w_any  = |in_valid;
  assign w_base = (MODE == 1) ? r_ptr : '0;
  // Scan from the far end so the first valid channel after w_base overwrites last.
  always_comb begin
    w_grant = '0;
    w_sum   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_sum = {1'b0, w_base} + (SELW + 1)'(k);
      w_sum = (w_sum >= (SELW + 1)'(N)) ? w_sum - (SELW + 1)'(N) : w_sum;
      w_grant = in_valid[w_sum[SELW-1:0]] ? w_sum[SELW-1:0] : w_grant;
    end
  end
  assign in_ready = (w_load & w_any & ~rst) ? (N'(1) << w_grant) : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sel   <= '0;
      r_ptr   <= '0;
    end else if (w_load) begin
      r_valid <= w_any;
      if (w_any) begin
        r_data <= in_data[w_grant*WIDTH +: WIDTH];
        r_sel  <= w_grant;
        if (MODE == 1) r_ptr <= (w_grant == SELW'(N - 1)) ? '0 : w_grant + SELW'(1);
      end
    end
  end
  assign out_data  = r_data;
  assign out_valid = r_valid;
  assign out_sel   = r_sel;
endmodule

// File: tb/tb_arb_mux.sv
// tb_arb_mux: checks fixed-priority and round-robin instances side by side against a reference model.
module tb_arb_mux;
  localparam int W = 32;
  localparam int N = 4;
  localparam logic [W-1:0] BASE = 32'hC0DE_0000;
  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   rdy0, rdy1;
  logic [W-1:0]   od0, od1;
  logic           ov0, ov1;
  logic           out_ready;
  logic [1:0]     os0, os1;
  bit             mv[2];
  logic [W-1:0]   md[2];
  int             ms[2];
  int             mp[2];
  int             pass_n = 0;
  int             tot_n = 0;
  int             acc = 0;
  int             con = 0;
  bit             counting = 0;
  typedef struct {
    logic [N-1:0] iv;
    logic         v;
    logic [1:0]   s0;
    logic [1:0]   s1;
  } vec_t;
  vec_t tbl[15];

  arb_mux #(.WIDTH(W), .N(N), .MODE(0)) u0 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy0),
    .out_data(od0), .out_valid(ov0), .out_ready(out_ready), .out_sel(os0));
  arb_mux #(.WIDTH(W), .N(N), .MODE(1)) u1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy1),
    .out_data(od1), .out_valid(ov1), .out_ready(out_ready), .out_sel(os1));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    tot_n++;
    if (a === e) pass_n++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
  endtask

  // Search order: p, p+1, ..., wrapping modulo N.
  function automatic int grant(input logic [N-1:0] iv, input int p);
    for (int k = 0; k < N; k++) if (iv[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_rdy(input int m);
    int g;
    g = grant(in_valid, mp[m]);
    return (!rst && (!mv[m] || out_ready) && g >= 0) ? N'(1) << g : '0;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mv[m] = 0; md[m] = '0; ms[m] = 0; mp[m] = 0;
    end
  endtask

  task automatic cyc();
    int g;
    #3;
    chk("rdy_m0", rdy0, exp_rdy(0));
    chk("rdy_m1", rdy1, exp_rdy(1));
    if (counting) begin
      acc += $countones(rdy1 & in_valid);
      if (ov1 && out_ready) con++;
    end
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      g = grant(in_valid, mp[m]);
      if (!mv[m] || out_ready) begin
        if (g >= 0) begin
          md[m] = in_data[g*W +: W]; ms[m] = g; mv[m] = 1;
          if (m == 1) mp[m] = (g + 1) % N;
        end else mv[m] = 0;
      end
    end
    #1;
    chk("valid_m0", ov0, mv[0]);
    chk("valid_m1", ov1, mv[1]);
    if (mv[0]) begin chk("data_m0", od0, md[0]); chk("sel_m0", os0, ms[0]); end
    if (mv[1]) begin chk("data_m1", od1, md[1]); chk("sel_m1", os1, ms[1]); end
  endtask

  initial begin
    tbl = '{
      '{4'b1111, 1'b1, 2'd0, 2'd0}, '{4'b1111, 1'b1, 2'd0, 2'd1},
      '{4'b1111, 1'b1, 2'd0, 2'd2}, '{4'b1111, 1'b1, 2'd0, 2'd3},
      '{4'b1111, 1'b1, 2'd0, 2'd0}, '{4'b1111, 1'b1, 2'd0, 2'd1},
      '{4'b1111, 1'b1, 2'd0, 2'd2}, '{4'b1111, 1'b1, 2'd0, 2'd3},
      '{4'b1010, 1'b1, 2'd1, 2'd1}, '{4'b1010, 1'b1, 2'd1, 2'd3},
      '{4'b1010, 1'b1, 2'd1, 2'd1}, '{4'b1010, 1'b1, 2'd1, 2'd3},
      '{4'b1100, 1'b1, 2'd2, 2'd2}, '{4'b0000, 1'b0, 2'd2, 2'd2},
      '{4'b1111, 1'b1, 2'd0, 2'd3}};
    rst = 1'b1; in_data = '0; in_valid = '0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    // Reset while a beat is held: outputs clear without waiting for a clock edge.
    in_data[0 +: W] = 32'h12345678; in_valid = 4'b0001;
    cyc();
    chk("hold_before_rst", od1, 32'h12345678);
    #2 in_valid = 4'b1111; rst = 1'b1;
    #1;
    chk("rst_valid", ov1, 0); chk("rst_data", od1, 0); chk("rst_sel", os1, 0);
    chk("rst_valid_m0", ov0, 0); chk("rst_rdy_m0", rdy0, 0); chk("rst_rdy_m1", rdy1, 0);
    model_reset();
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = BASE + W'(i);
    out_ready = 1'b1;
    for (int r = 0; r < 15; r++) begin
      in_valid = tbl[r].iv;
      cyc();
      chk($sformatf("tbl%0d_valid", r), {ov1, ov0}, {tbl[r].v, tbl[r].v});
      chk($sformatf("tbl%0d_sel_m0", r), os0, tbl[r].s0);
      chk($sformatf("tbl%0d_sel_m1", r), os1, tbl[r].s1);
      if (tbl[r].v) chk($sformatf("tbl%0d_data", r), od1, BASE + W'(tbl[r].s1));
    end
    // Single request on channel 2.
    in_data[2*W +: W] = 32'hDEADBEEF; in_valid = 4'b0100;
    #1 chk("single_rdy", rdy1, 4'b0100);
    cyc();
    chk("single_data", od1, 32'hDEADBEEF); chk("single_sel", os1, 2);
    // Backpressure: hold A5A5A5A5 while the consumer stalls.
    in_data[1*W +: W] = 32'hA5A5A5A5; in_valid = 4'b0010;
    cyc();
    in_valid = 4'b1111; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_rdy", {rdy1, rdy0}, 8'h00);
      chk("stall_data", od1, 32'hA5A5A5A5); chk("stall_sel", os1, 1);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("resume_valid", ov1, 1);
    end
    in_valid = '0;
    cyc();
    // Random traffic, with beat accounting across the whole window.
    counting = 1;
    for (int i = 0; i < 400; i++) begin
      in_data = {$urandom, $urandom, $urandom, $urandom};
      in_valid = N'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    in_valid = '0; out_ready = 1'b1;
    cyc(); cyc();
    counting = 0;
    chk("beats_in_vs_out", con, acc);
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
